// File: rtl/maple_stim_pkg.sv
// Shared types and helpers for the AXI4-Stream stimulus generator: FSM state
// encoding, pattern mode encoding and the 32-bit Galois LFSR step.
package maple_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  typedef enum logic {
    MODE_INC  = 1'b0,
    MODE_LFSR = 1'b1
  } mode_t;

  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

  // An all-zero LFSR state would lock up, so a zero seed becomes 1.
  function automatic logic [31:0] lfsr_seed_fix(input logic [31:0] s);
    lfsr_seed_fix = (s == 32'd0) ? 32'd1 : s;
  endfunction

endpackage

// File: rtl/stim_lfsr32.sv
// 32-bit Galois LFSR with synchronous load (zero seed forced to 1) and
// per-cycle advance enable. Only built when AXIS_PKT_GEN_LFSR_EN is defined.
module stim_lfsr32
  import maple_stim_pkg::*;
(
  input  logic        aclk,
  input  logic        areset,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] state
);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= 32'd1;
    end else if (load) begin
      state <= lfsr_seed_fix(seed);
    end else if (advance) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream packet generator: programmable length, count, gap and pattern.
// Define AXIS_PKT_GEN_LFSR_EN to build the LFSR pattern selected by cfg_mode.
module axis_pkt_gen
  import maple_stim_pkg::*;
#(
  parameter int TDATA_WIDTH    = 8,
  parameter int LEN_WIDTH      = 8,
  parameter int NPKT_WIDTH     = 16,
  parameter int GAP_WIDTH      = 8,
  parameter int BEAT_CNT_WIDTH = 32
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      start,
  input  logic [LEN_WIDTH-1:0]      cfg_len,
  input  logic [NPKT_WIDTH-1:0]     cfg_npkt,
  input  logic [GAP_WIDTH-1:0]      cfg_gap,
  input  logic                      cfg_mode,
  input  logic [31:0]               cfg_seed,
  output logic                      busy,
  output logic                      done,
  output logic [BEAT_CNT_WIDTH-1:0] beats_sent,
  output logic [TDATA_WIDTH-1:0]    m_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [1:0]                state_dbg
);

  // Stream handshake: a beat transfers on a rising edge where tvalid and tready
  // are both high; tvalid, tdata and tlast only change after that transfer.
  localparam logic [LEN_WIDTH-1:0]      LEN_ONE  = 1;
  localparam logic [NPKT_WIDTH-1:0]     NPKT_ONE = 1;
  localparam logic [GAP_WIDTH-1:0]      GAP_ONE  = 1;
  localparam logic [BEAT_CNT_WIDTH-1:0] BEAT_ONE = 1;
  localparam logic [TDATA_WIDTH-1:0]    DATA_ONE = 1;

  state_t                  state;
  logic [LEN_WIDTH-1:0]    len_q, beat_idx, beat_nxt, len_eff;
  logic [NPKT_WIDTH-1:0]   npkt_q, pkt_idx;
  logic [GAP_WIDTH-1:0]    gap_q, gap_cnt;
  logic [TDATA_WIDTH-1:0]  seed_data, data_nxt;
  logic                    last_pkt;

  assign len_eff   = (cfg_len == '0) ? LEN_ONE : cfg_len;
  assign beat_nxt  = beat_idx + LEN_ONE;
  assign last_pkt  = ((pkt_idx + NPKT_ONE) == npkt_q);
  assign state_dbg = state;

`ifdef AXIS_PKT_GEN_LFSR_EN
  mode_t       mode_q;
  logic [31:0] lfsr_state, lfsr_nxt, seed_fix;
  logic        lfsr_load, unused_lfsr;

  assign lfsr_load = (state == ST_IDLE) && start;
  assign lfsr_nxt  = lfsr_step(lfsr_state);
  assign seed_fix  = lfsr_seed_fix(cfg_seed);

  stim_lfsr32 u_lfsr (
    .aclk    (aclk),
    .areset  (areset),
    .load    (lfsr_load),
    .seed    (cfg_seed),
    .advance (m_axis_tvalid & m_axis_tready),
    .state   (lfsr_state)
  );

  assign seed_data = (mode_t'(cfg_mode) == MODE_LFSR) ? seed_fix[TDATA_WIDTH-1:0]
                                                       : cfg_seed[TDATA_WIDTH-1:0];
  assign data_nxt  = (mode_q == MODE_LFSR) ? lfsr_nxt[TDATA_WIDTH-1:0]
                                            : m_axis_tdata + DATA_ONE;
  assign unused_lfsr = ^{lfsr_nxt, seed_fix};

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      mode_q <= MODE_INC;
    end else if (lfsr_load) begin
      mode_q <= mode_t'(cfg_mode);
    end
  end
`else
  logic unused_cfg;
  assign seed_data  = cfg_seed[TDATA_WIDTH-1:0];
  assign data_nxt   = m_axis_tdata + DATA_ONE;
  assign unused_cfg = ^{cfg_mode, cfg_seed};
`endif

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= ST_IDLE;
      len_q         <= '0;
      npkt_q        <= '0;
      gap_q         <= '0;
      beat_idx      <= '0;
      pkt_idx       <= '0;
      gap_cnt       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      beats_sent    <= '0;
      m_axis_tdata  <= '0;
      m_axis_tstrb  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            len_q        <= len_eff;
            npkt_q       <= cfg_npkt;
            gap_q        <= cfg_gap;
            beat_idx     <= '0;
            pkt_idx      <= '0;
            m_axis_tdata <= seed_data;
            m_axis_tlast <= (len_eff == LEN_ONE);
            if (cfg_npkt == '0) begin
              state <= ST_FIN;
              done  <= 1'b1;
            end else begin
              state         <= ST_SEND;
              busy          <= 1'b1;
              m_axis_tvalid <= 1'b1;
              m_axis_tstrb  <= '1;
            end
          end
        end
        ST_SEND: begin
          if (m_axis_tready) begin
            beats_sent   <= beats_sent + BEAT_ONE;
            m_axis_tdata <= data_nxt;
            if (m_axis_tlast) begin
              beat_idx     <= '0;
              pkt_idx      <= pkt_idx + NPKT_ONE;
              m_axis_tlast <= (len_q == LEN_ONE);
              if (last_pkt) begin
                state         <= ST_FIN;
                busy          <= 1'b0;
                done          <= 1'b1;
                m_axis_tvalid <= 1'b0;
                m_axis_tstrb  <= '0;
              end else if (gap_q != '0) begin
                state         <= ST_GAP;
                gap_cnt       <= gap_q;
                m_axis_tvalid <= 1'b0;
                m_axis_tstrb  <= '0;
              end
            end else begin
              beat_idx     <= beat_nxt;
              m_axis_tlast <= (beat_nxt == (len_q - LEN_ONE));
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_ONE) begin
            state         <= ST_SEND;
            m_axis_tvalid <= 1'b1;
            m_axis_tstrb  <= '1;
          end else begin
            gap_cnt <= gap_cnt - GAP_ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed bench for axis_pkt_gen: expected beats queued at stimulus time,
// popped and compared by an independent monitor on every accepted beat.
module tb_axis_pkt_gen;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  cfg_len = '0;
  logic [15:0] cfg_npkt = '0;
  logic [7:0]  cfg_gap = '0;
  logic        cfg_mode = 1'b0;
  logic [31:0] cfg_seed = '0;
  logic        busy, done;
  logic [31:0] beats_sent;
  logic [7:0]  m_axis_tdata;
  logic [0:0]  m_axis_tstrb;
  logic        m_axis_tlast, m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic [1:0]  state_dbg;

  logic [8:0]  exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic        rdy_rand = 1'b0;

  axis_pkt_gen #(
    .TDATA_WIDTH(8), .LEN_WIDTH(8), .NPKT_WIDTH(16), .GAP_WIDTH(8), .BEAT_CNT_WIDTH(32)
  ) dut (
    .aclk(aclk), .areset(areset), .start(start), .cfg_len(cfg_len), .cfg_npkt(cfg_npkt),
    .cfg_gap(cfg_gap), .cfg_mode(cfg_mode), .cfg_seed(cfg_seed), .busy(busy), .done(done),
    .beats_sent(beats_sent), .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic start_run(input logic [7:0] len, input logic [15:0] npkt, input logic [7:0] gap,
                           input logic mode, input logic [31:0] seed);
    cfg_len = len; cfg_npkt = npkt; cfg_gap = gap; cfg_mode = mode; cfg_seed = seed;
    start = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  task automatic push_inc(input logic [7:0] seed, input int len, input int npkt);
    int leff;
    logic [7:0] d;
    leff = (len == 0) ? 1 : len;
    d = seed;
    for (int p = 0; p < npkt; p++)
      for (int b = 0; b < leff; b++) begin
        exp_q.push_back({(b == leff - 1), d});
        d = d + 8'd1;
      end
  endtask

  // Called in cycle 1 of a run; exp_cyc < 0 means the latency is not fixed.
  task automatic wait_done(input string name, input int exp_cyc);
    int n;
    n = 1;
    while (!done && n < 2000) begin
      next_cycle();
      n++;
    end
    if (!done) begin
      chk({name, "_timeout"}, 64'(n), 64'(exp_cyc));
    end else begin
      if (exp_cyc >= 0) chk({name, "_done_cycle"}, 64'(n), 64'(exp_cyc));
      chk({name, "_tvalid_at_done"}, 64'(m_axis_tvalid), 64'd0);
      chk({name, "_busy_at_done"}, 64'(busy), 64'd0);
      next_cycle();
      chk({name, "_done_pulse"}, 64'(done), 64'd0);
      chk({name, "_idle"}, 64'(state_dbg), 64'd0);
    end
    chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      if (rdy_rand) m_axis_tready = 1'($urandom_range(0, 1));
    end
  end

  // scoreboard monitor
  initial begin
    logic       held_v;
    logic [8:0] held;
    logic [8:0] e;
    held_v = 1'b0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          chk("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
          chk("stall_beat", 64'({m_axis_tlast, m_axis_tdata}), 64'(held));
        end
        if (m_axis_tvalid) chk("tstrb", 64'(m_axis_tstrb), 64'd1);
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 64'({m_axis_tlast, m_axis_tdata}), 64'h1ff);
          end else begin
            e = exp_q.pop_front();
            chk("beat", 64'({m_axis_tlast, m_axis_tdata}), 64'(e));
          end
          held_v = 1'b0;
        end else if (m_axis_tvalid) begin
          held_v = 1'b1;
          held = {m_axis_tlast, m_axis_tdata};
        end else begin
          held_v = 1'b0;
        end
      end
    end
  end

  initial begin
    next_cycle();
    next_cycle();
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("rst_tstrb", 64'(m_axis_tstrb), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_beats", 64'(beats_sent), 64'd0);
    areset = 1'b0;
    next_cycle();
    chk("rst_state", 64'(state_dbg), 64'd0);

    // len=5 single packet from seed 0
    push_inc(8'h00, 5, 1);
    start_run(8'd5, 16'd1, 8'd0, 1'b0, 32'h0);
    chk("t1_first_valid", 64'(m_axis_tvalid), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    wait_done("t1", 6);
    chk("t1_beats_sent", 64'(beats_sent), 64'd5);

    // two packets with gap, data wraps through 0xFF
    exp_q.push_back(9'h0fe); exp_q.push_back(9'h0ff); exp_q.push_back(9'h100);
    exp_q.push_back(9'h001); exp_q.push_back(9'h002); exp_q.push_back(9'h103);
    start_run(8'd3, 16'd2, 8'd2, 1'b0, 32'h0000_00fe);
    wait_done("t2", 9);
    chk("t2_beats_sent", 64'(beats_sent), 64'd11);

    // random backpressure, start while busy must be ignored
    push_inc(8'h00, 4, 3);
    rdy_rand = 1'b1;
    start_run(8'd4, 16'd3, 8'd0, 1'b0, 32'h0);
    cfg_seed = 32'h55; cfg_len = 8'd1; start = 1'b1;
    next_cycle();
    start = 1'b0;
    wait_done("t3", -1);
    rdy_rand = 1'b0;
    m_axis_tready = 1'b1;
    chk("t3_beats_sent", 64'(beats_sent), 64'd23);

    // zero packets: no beats, done one cycle after start
    start_run(8'd4, 16'd0, 8'd0, 1'b0, 32'h0);
    wait_done("t4", 1);
    chk("t4_beats_sent", 64'(beats_sent), 64'd23);

    // len=0 behaves as single-beat packets
    exp_q.push_back(9'h110); exp_q.push_back(9'h111);
    start_run(8'd0, 16'd2, 8'd0, 1'b0, 32'h10);
    wait_done("t5", 3);
    chk("t5_beats_sent", 64'(beats_sent), 64'd25);

    // reset mid-packet with a start while busy, then a clean restart
    push_inc(8'h20, 5, 1);
    start_run(8'd5, 16'd1, 8'd0, 1'b0, 32'h20);
    cfg_seed = 32'h99; cfg_len = 8'd2; start = 1'b1;
    next_cycle();
    start = 1'b0;
    next_cycle();
    chk("t6_beat2_data", 64'(m_axis_tdata), 64'h22);
    chk("t6_beat2_busy", 64'(busy), 64'd1);
    areset = 1'b1;
    #1;
    chk("t6_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_beats", 64'(beats_sent), 64'd0);
    chk("t6_rst_tdata", 64'(m_axis_tdata), 64'd0);
    exp_q.delete();
    next_cycle();
    areset = 1'b0;
    next_cycle();
    push_inc(8'h20, 5, 1);
    start_run(8'd5, 16'd1, 8'd0, 1'b0, 32'h20);
    wait_done("t6", 6);
    chk("t6_beats_sent", 64'(beats_sent), 64'd5);

    // mode=1 with seed 0
`ifdef AXIS_PKT_GEN_LFSR_EN
    exp_q.push_back(9'h001); exp_q.push_back(9'h003);
    exp_q.push_back(9'h002); exp_q.push_back(9'h101);
`else
    exp_q.push_back(9'h000); exp_q.push_back(9'h001);
    exp_q.push_back(9'h002); exp_q.push_back(9'h103);
`endif
    start_run(8'd4, 16'd1, 8'd0, 1'b1, 32'h0);
    wait_done("t7", 5);
    chk("t7_beats_sent", 64'(beats_sent), 64'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
